camera_downsampler: RTL

- Upstream stage of the image processor. Takes the OV7670 RGB565 byte stream (two bytes per pixel, framed by CAM_HREF/CAM_VSYNC) and packs each pixel into RGB332.
- Writes each pixel into the 176x144 frame buffer using a linear address.
- The buffer's read side feeds the VGA driver and the colour-classifying image processor, which consume the same 8-bit RGB332 pixel format.

---
 rtl/camera_downsampler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/camera_downsampler.sv
// rtl/camera_downsampler.sv - OV7670 RGB565 byte stream to RGB332 frame-buffer writer.
// Define CAMERA_DOWNSAMPLER_TEST_PATTERN_EN to replace camera pixels with red/green/blue row bars.
module camera_downsampler #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_WIDTH    = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            CAM_DATA,
  input  logic                  CAM_HREF,
  input  logic                  CAM_VSYNC,
  output logic [7:0]            PIXEL_OUT,
  output logic [ADDR_WIDTH-1:0] WRITE_ADDR,
  output logic                  W_EN,
  output logic                  FRAME_DONE,
  output logic [ADDR_WIDTH:0]   PIXELS_WRITTEN
);

  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0]         X_LIM    = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0]         Y_LIM    = YW'(SCREEN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(SCREEN_WIDTH);

  typedef enum logic [1:0] {WAIT_FRAME, FIRST_BYTE, SECOND_BYTE} state_t;

  state_t                state, state_next;
  logic                  href_q, vsync_q;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH:0]   count;
  logic [5:0]            hi_bits;
  logic                  href_fall, vsync_rise, vsync_fall;
  logic                  latch_hi, pixel_done, write_now, active;
  logic [7:0]            pixel_next;

  assign href_fall  = href_q & ~CAM_HREF;
  assign vsync_rise = ~vsync_q & CAM_VSYNC;
  assign vsync_fall = vsync_q & ~CAM_VSYNC;
  assign active     = (state != WAIT_FRAME);
  assign write_now  = pixel_done && (x < X_LIM) && (y < Y_LIM);

`ifdef CAMERA_DOWNSAMPLER_TEST_PATTERN_EN
  localparam logic [YW-1:0] BAR1 = YW'(SCREEN_HEIGHT / 3);
  localparam logic [YW-1:0] BAR2 = YW'(2 * (SCREEN_HEIGHT / 3));
  always_comb begin
    pixel_next = 8'h03;
    if (y < BAR1)      pixel_next = 8'hE0;
    else if (y < BAR2) pixel_next = 8'h1C;
  end
`else
  assign pixel_next = {hi_bits, CAM_DATA[4:3]};
`endif

  always_comb begin
    state_next = state;
    latch_hi   = 1'b0;
    pixel_done = 1'b0;
    case (state)
      WAIT_FRAME:  if (vsync_fall) state_next = FIRST_BYTE;
      FIRST_BYTE:  if (CAM_HREF) begin
                     latch_hi   = 1'b1;
                     state_next = SECOND_BYTE;
                   end
      SECOND_BYTE: if (CAM_HREF) begin
                     pixel_done = 1'b1;
                     state_next = FIRST_BYTE;
                   end
      default:     state_next = WAIT_FRAME;
    endcase
    // Row or frame boundary realigns byte phase; an odd trailing byte is dropped.
    if (active && (vsync_rise || href_fall)) state_next = FIRST_BYTE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= WAIT_FRAME;
      href_q         <= 1'b0;
      vsync_q        <= 1'b0;
      x              <= '0;
      y              <= '0;
      row_base       <= '0;
      count          <= '0;
      hi_bits        <= '0;
      PIXEL_OUT      <= '0;
      WRITE_ADDR     <= '0;
      W_EN           <= 1'b0;
      FRAME_DONE     <= 1'b0;
      PIXELS_WRITTEN <= '0;
    end else begin
      state      <= state_next;
      href_q     <= CAM_HREF;
      vsync_q    <= CAM_VSYNC;
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (latch_hi) hi_bits <= {CAM_DATA[7:5], CAM_DATA[2:0]};
      if (write_now) begin
        W_EN       <= 1'b1;
        PIXEL_OUT  <= pixel_next;
        WRITE_ADDR <= row_base + ADDR_WIDTH'(x);
      end
      if (active && vsync_rise) begin
        // A pixel completing on the closing edge still belongs to this frame.
        FRAME_DONE     <= 1'b1;
        PIXELS_WRITTEN <= count + {{ADDR_WIDTH{1'b0}}, write_now};
        x              <= '0;
        y              <= '0;
        row_base       <= '0;
        count          <= '0;
      end else if (active && href_fall) begin
        x <= '0;
        if (y < Y_LIM) begin
          y        <= y + 1'b1;
          row_base <= row_base + ROW_STEP;
        end
      end else if (pixel_done) begin
        if (x < X_LIM) x <= x + 1'b1;
        if (write_now) count <= count + 1'b1;
      end
    end
  end

endmodule
